// File: rtl/memwb_stage.sv
// MEM/WB pipeline register: tracks the data-bus handshake of the MEM instruction and stalls until it completes.
// Optional DBUS_WATCHDOG_EN adds a sticky dbus_timeout output after TIMEOUT_CYCLES cycles spent waiting on the bus.
module memwb_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        valid_m,
  input  logic        req_valid_m,
  input  logic        addr_ok,
  input  logic        data_ok,
  input  logic [31:0] ReadData,
  input  logic [31:0] ALUoutM,
  input  logic [4:0]  rdM,
  input  logic        regwrite_m,
  input  logic        memtoreg_m,
  input  logic [11:0] errorM,
  input  logic [31:0] BadVaddrM,
  input  logic [31:0] pc_m,
  input  logic        flush,
  output logic        req_mask,
  output logic        stall_m,
  output logic        valid_w,
  output logic [31:0] ReadDataW,
  output logic [31:0] ALUoutW,
  output logic [31:0] BadVaddrW,
  output logic [31:0] pc_w,
  output logic [4:0]  rdW,
  output logic        regwrite_w,
  output logic        memtoreg_w,
  output logic [11:0] errorW
`ifdef DBUS_WATCHDOG_EN
  ,
  output logic        dbus_timeout
`endif
);

  typedef enum logic [1:0] {IDLE, WAIT_DATA, DRAIN} state_t;

  state_t      state_q, state_d;
  logic        access;
  logic        load_w;
  logic        valid_q, regwrite_q, memtoreg_q;
  logic [31:0] rdata_q, aluout_q, badvaddr_q, pc_q;
  logic [4:0]  rd_q;
  logic [11:0] error_q;

  always_comb begin
    access   = valid_m & req_valid_m;
    state_d  = state_q;
    req_mask = 1'b0;
    stall_m  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (access) begin
          // A flush must proceed; an address it orphans still owes a response.
          if (flush) begin
            if (addr_ok & ~data_ok) state_d = DRAIN;
          end else if (~(addr_ok & data_ok)) begin
            stall_m = 1'b1;
            if (addr_ok) state_d = WAIT_DATA;
          end
        end
      end
      WAIT_DATA: begin
        req_mask = 1'b1;
        if (data_ok)    state_d = IDLE;
        else if (flush) state_d = DRAIN;
        else            stall_m = 1'b1;
      end
      DRAIN: begin
        req_mask = 1'b1;
        stall_m  = 1'b1;
        if (data_ok) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    load_w = valid_m & ~flush & ~stall_m;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
      rdata_q    <= '0;
      aluout_q   <= '0;
      badvaddr_q <= '0;
      pc_q       <= '0;
      rd_q       <= '0;
      error_q    <= '0;
    end else begin
      state_q    <= state_d;
      valid_q    <= load_w;
      regwrite_q <= load_w & regwrite_m;
      if (load_w) begin
        memtoreg_q <= memtoreg_m;
        rdata_q    <= ReadData;
        aluout_q   <= ALUoutM;
        badvaddr_q <= BadVaddrM;
        pc_q       <= pc_m;
        rd_q       <= rdM;
        error_q    <= errorM;
      end
    end
  end

  assign valid_w    = valid_q;
  assign regwrite_w = regwrite_q;
  assign memtoreg_w = memtoreg_q;
  assign ReadDataW  = rdata_q;
  assign ALUoutW    = aluout_q;
  assign BadVaddrW  = badvaddr_q;
  assign pc_w       = pc_q;
  assign rdW        = rd_q;
  assign errorW     = error_q;

`ifdef DBUS_WATCHDOG_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

  logic          bus_done, bus_busy, timeout_q;
  logic [CW-1:0] wd_cnt_q, wd_cnt_d;

  always_comb begin
    bus_done = data_ok & ((state_q != IDLE) | (access & addr_ok));
    bus_busy = stall_m | (state_q != IDLE);
    wd_cnt_d = wd_cnt_q;
    if (bus_done)                           wd_cnt_d = '0;
    else if (bus_busy && wd_cnt_q != LIMIT) wd_cnt_d = wd_cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wd_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_cnt_q  <= wd_cnt_d;
      timeout_q <= timeout_q | (wd_cnt_d == LIMIT);
    end
  end

  assign dbus_timeout = timeout_q;
`endif

endmodule

// File: doc/memwb_stage.md
Name: memwb_stage

Overview:
- Sits directly downstream of the memory stage.
- Tracks the data-bus handshake of the instruction currently in MEM and raises a stall to the hazard unit until the access completes.
- Registers the MEM results (ReadData, ALUoutM, rdM, errorM, BadVaddrM, PC, control) into the MEM/WB pipeline register.
- Emits a bubble in writeback while stalled and safely drains a bus transaction that a flush has orphaned.

Parameters:
- TIMEOUT_CYCLES, 1024, cycles waiting on the bus before the watchdog fires (used only with DBUS_WATCHDOG_EN).

Ports:
- clk  in  1  clock
- resetn  in  1  reset, asynchronous, active-low
- valid_m  in  1  MEM holds a live instruction
- req_valid_m  in  1  memory stage's dbus req.valid (already gated by adel/ades)
- addr_ok  in  1  dbus resp.addr_ok
- data_ok  in  1  dbus resp.data_ok
- ReadData  in  32  extended load data from memory stage (valid when data_ok)
- ALUoutM  in  32  address/ALU result
- rdM  in  5  destination register
- regwrite_m  in  1  instruction writes GPR
- memtoreg_m  in  1  writeback selects load data
- errorM  in  12  exception vector
- BadVaddrM  in  32  bad virtual address
- pc_m  in  32  PC of MEM instruction
- flush  in  1  exception/eret flush of MEM
- req_mask  out  1  1 = memory stage must deassert req.valid (address already accepted)
- stall_m  out  1  stall MEM and all upstream stages
- valid_w  out  1  WB holds a live instruction
- ReadDataW, ALUoutW, BadVaddrW, pc_w  out  32 each  registered copies
- rdW  out  5  registered rdM
- regwrite_w, memtoreg_w  out  1 each  registered controls
- errorW  out  12  registered errorM

Behaviour:
- Reset (async, resetn=0): state=IDLE; every output register 0; req_mask=0; stall_m=0.
- The FSM has three states: IDLE, WAIT_DATA, DRAIN.
- IDLE, valid_m=1 & req_valid_m=1 & ~flush:
  - addr_ok & data_ok in the same cycle: complete. Capture on this edge, stall_m=0.
  - addr_ok only: go to WAIT_DATA, stall_m=1.
  - neither: stay in IDLE, stall_m=1 (request is re-presented).
- IDLE, no memory access (valid_m=0 or req_valid_m=0): stall_m=0. Capture every edge (single-cycle pass-through, latency 1).
- WAIT_DATA:
  - req_mask=1. stall_m=1 until data_ok.
  - On data_ok: capture ReadData plus all side fields, go to IDLE. stall_m=0 in the data_ok cycle.
  - flush while waiting: go to DRAIN. stall_m=0 so the flush proceeds.
- DRAIN: req_mask=1, stall_m=1. Discard the response on data_ok (valid_w stays 0), then go to IDLE. This prevents a stale response being matched to the next request.
- Flush in IDLE with addr_ok=1 and data_ok=0 in the same cycle: go directly to DRAIN.
- Flush with no outstanding transaction: next valid_w=0, stall_m=0.
- Capture rule:
  - valid_w <= valid_m & ~flush & ~stall_m.
  - When valid_w is loaded 0, the data fields hold their previous values, except regwrite_w, which is forced to 0.
- errorW is copied bit-exact. A faulting access (req_valid_m=0 due to adel/ades) passes in one cycle with errorW set.
- data_ok arriving in IDLE (protocol violation) is ignored.

Optional Feature:
- Macro: DBUS_WATCHDOG_EN.
- Defined:
  - Adds output dbus_timeout (1 bit, sticky, cleared only by reset).
  - Adds a counter that counts cycles spent in WAIT_DATA, DRAIN, or IDLE-with-stall. The counter clears on any completion.
  - dbus_timeout sets when the counter reaches TIMEOUT_CYCLES; the counter saturates there.
- Undefined: no counter and no dbus_timeout port; behaviour otherwise identical.

Test Plan:
- Load, addr_ok=data_ok=1 in the same cycle, ReadData=0xDEADBEEF, rdM=5 -> next edge valid_w=1, ReadDataW=0xDEADBEEF, rdW=5, stall_m never 1.
- Store, addr_ok at cycle 0, data_ok at cycle 3 -> stall_m=1 cycles 0-2; req_mask=1 cycles 1-3; valid_w=1 after cycle 3; state back to IDLE.
- Load with addr_ok held low 4 cycles, then addr_ok&data_ok -> stall_m=1 for 4 cycles, req_mask stays 0, single capture.
- Flush in WAIT_DATA, data_ok 2 cycles later with ReadData=0x12345678 -> state DRAIN, valid_w=0, ReadDataW unchanged; next load completes normally.
- adel fault (req_valid_m=0, errorM[5]=1, BadVaddrM=0x00000003) -> one-cycle pass, errorW[5]=1, BadVaddrW=0x00000003, stall_m=0.
- With DBUS_WATCHDOG_EN, TIMEOUT_CYCLES=8, addr_ok and data_ok never asserted -> dbus_timeout=1 after 8 stalled cycles; remains 1 until resetn=0; resetn mid-WAIT_DATA -> state IDLE, all outputs 0.
